logical_not_stage: RTL

// Registered valid/ready stage that feeds the LogicalNOT operator and buffers its result.
// - Accepts N-bit operands from the upstream datapath.
// - Evaluates c = !a (1 when a == 0) through a LogicalNOT instance.
// - Stores {a, c} in a 2-entry skid FIFO for the downstream consumer.
// - Keeps a saturating count of zero operands for the BasicCombinationalLogic test harness.

---
 rtl/logical_not_stage_if.sv | 7 +
 rtl/logical_not_stage.sv | 93 +++++++++
 2 files changed

// File: rtl/logical_not_stage_if.sv
// logical_not_stage_if: upstream operand and downstream result handshakes of the NOT stage
interface logical_not_stage_if #(parameter int N = 8);
    logic         s_valid, s_ready, m_valid, m_ready, m_c;
    logic [N-1:0] s_a, m_a;
    modport master (output s_valid, s_a, m_ready, input s_ready, m_valid, m_a, m_c);
    modport slave  (input s_valid, s_a, m_ready, output s_ready, m_valid, m_a, m_c);
endinterface

// File: rtl/logical_not_stage.sv
// logical_not_stage: valid/ready stage evaluating c = !a into a 2-entry skid FIFO with a saturating zero count
module LogicalNOT #(
    parameter string MODEL = "Structural",
    parameter int    N     = 8
) (
    input  logic [N-1:0] a,
    output logic         c
);
    generate
        if (MODEL == "Behavioral") begin : g_beh
            always_comb begin
                c = 1'b1;
                for (int i = 0; i < N; i++) if (a[i]) c = 1'b0;
            end
        end else if (MODEL == "DataFlow") begin : g_df
            assign c = (a == '0);
        end else begin : g_str
            logic [N:0] any;
            assign any[0] = 1'b0;
            for (genvar g = 0; g < N; g++) begin : g_or
                or u_or (any[g+1], any[g], a[g]);
            end
            not u_not (c, any[N]);
        end
    endgenerate
endmodule

module logical_not_stage #(
    parameter string MODEL = "Structural",
    parameter int    N     = 8,
    parameter int    CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    logical_not_stage_if.slave   bus,
    input  logic                 clr_count,
    output logic [CNT_W-1:0]     zero_count
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t             state_q, state_d;
    logic               wr_q, wr_d, rd_q, rd_d, s_ready_q, s_ready_d;
    logic [N-1:0]       a_q [2];
    logic [N-1:0]       a_d [2];
    logic [1:0]         c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c, push, pop;

    LogicalNOT #(.MODEL(MODEL), .N(N)) u_not (.a(bus.s_a), .c(c));

    assign push        = bus.s_valid & s_ready_q;
    assign pop         = bus.m_valid & bus.m_ready;
    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = (state_q != EMPTY);
    assign bus.m_a     = a_q[rd_q];
    assign bus.m_c     = c_q[rd_q];
    assign zero_count  = cnt_q;

    always_comb begin
        a_d = a_q;
        c_d = c_q;
        if (push) begin
            a_d[wr_q] = bus.s_a;
            c_d[wr_q] = c;
        end
        wr_d      = wr_q ^ push;
        rd_d      = rd_q ^ pop;
        state_d   = (push & ~pop) ? ((state_q == EMPTY) ? ONE : FULL) :
                    (~push & pop) ? ((state_q == FULL) ? ONE : EMPTY) : state_q;
        // ready is registered from the next state so m_ready never reaches s_ready combinationally
        s_ready_d = (state_d != FULL);
        cnt_d     = clr_count ? '0 : (push & c & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            s_ready_q <= 1'b0;
            a_q       <= '{default: '0};
            c_q       <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            s_ready_q <= s_ready_d;
            a_q       <= a_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule
